// File: rtl/char_stream_buffer.sv
// char_stream_buffer: captures strobed characters into a buffer until eof, then serves them by random read and in-order stream.
// Ports:
//   clk, resetn            system clock, asynchronous active-low reset
//   char_ready, next_char  asynchronous write strobe and its character code
//   eof                    asynchronous end-of-text level
//   restart                synchronous pulse: discard contents, back to FILL
//   sel / sel_char         random-read address / registered data (0 beyond count)
//   out_char/out_valid/out_ready  in-order valid/ready stream
//   count, full, overflow, state, debug  status
module char_stream_buffer #(
  parameter int CHAR_W      = 6,
  parameter int ADDR_W      = 12,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              char_ready,
  input  logic [CHAR_W-1:0] next_char,
  input  logic              eof,
  input  logic              restart,
  input  logic [ADDR_W-1:0] sel,
  output logic [CHAR_W-1:0] sel_char,
  output logic [CHAR_W-1:0] out_char,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              overflow,
  output logic [1:0]        state,
  output logic [CHAR_W+1:0] debug
);
  typedef enum logic [1:0] {FILL = 2'd0, LOADED = 2'd1, DONE = 2'd2} state_e;
  localparam int DEPTH = 1 << ADDR_W;
  logic [SYNC_STAGES-1:0] cr_sync_q, eof_sync_q;
  logic                   cr_prev_q, eof_prev_q;
  state_e                 state_q, state_d;
  logic [ADDR_W:0]        count_q, count_d, rd_ptr_q, rd_ptr_d, nxt_ptr;
  logic                   overflow_q, overflow_d, out_valid_q, out_valid_d;
  logic [CHAR_W-1:0]      out_char_q, out_char_d, sel_char_q;
  logic [CHAR_W-1:0]      mem [DEPTH];
  logic                   cr_s, eof_s, wr_pulse, eof_rise, full_w, do_write, hs, last;

  assign cr_s     = cr_sync_q[SYNC_STAGES-1];
  assign eof_s    = eof_sync_q[SYNC_STAGES-1];
  assign wr_pulse = cr_s & ~cr_prev_q;
  assign eof_rise = eof_s & ~eof_prev_q;
  // count only reaches 2^ADDR_W when every slot is used, so its MSB is the full flag
  assign full_w   = count_q[ADDR_W];
  assign do_write = state_q == FILL && wr_pulse && !full_w && !restart;
  assign hs       = out_valid_q && out_ready;
  assign last     = rd_ptr_q == count_q - 1'b1;
  assign nxt_ptr  = rd_ptr_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    out_valid_d = out_valid_q;
    out_char_d  = out_char_q;
    rd_ptr_d    = rd_ptr_q;
    if (restart) begin
      state_d     = FILL;
      count_d     = '0;
      overflow_d  = 1'b0;
      out_valid_d = 1'b0;
      rd_ptr_d    = '0;
    end else if (state_q == FILL) begin
      if (wr_pulse) begin
        if (full_w) overflow_d = 1'b1;
        else count_d = count_q + 1'b1;
      end
      // a write in the same cycle still lands; LOADED sees the final count
      if (eof_rise) state_d = LOADED;
    end else if (state_q == LOADED) begin
      if (hs) begin
        if (last) begin
          out_valid_d = 1'b0;
          state_d     = DONE;
        end else begin
          rd_ptr_d   = nxt_ptr;
          out_char_d = mem[nxt_ptr[ADDR_W-1:0]];
        end
      end else if (!out_valid_q) begin
        if (count_q == '0) state_d = DONE;
        else begin
          out_valid_d = 1'b1;
          out_char_d  = mem[rd_ptr_q[ADDR_W-1:0]];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cr_sync_q   <= '0;
      eof_sync_q  <= '0;
      cr_prev_q   <= 1'b0;
      eof_prev_q  <= 1'b0;
      state_q     <= FILL;
      count_q     <= '0;
      rd_ptr_q    <= '0;
      overflow_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_char_q  <= '0;
      sel_char_q  <= '0;
    end else begin
      cr_sync_q   <= {cr_sync_q[SYNC_STAGES-2:0], char_ready};
      eof_sync_q  <= {eof_sync_q[SYNC_STAGES-2:0], eof};
      cr_prev_q   <= cr_s;
      eof_prev_q  <= eof_s;
      state_q     <= state_d;
      count_q     <= count_d;
      rd_ptr_q    <= rd_ptr_d;
      overflow_q  <= overflow_d;
      out_valid_q <= out_valid_d;
      out_char_q  <= out_char_d;
      sel_char_q  <= ({1'b0, sel} < count_q) ? mem[sel] : '0;
    end
  end

  // buffer contents survive reset and restart; only count decides what is visible
  always_ff @(posedge clk) begin
    if (do_write) mem[count_q[ADDR_W-1:0]] <= next_char;
  end

  assign sel_char  = sel_char_q;
  assign out_char  = out_char_q;
  assign out_valid = out_valid_q;
  assign count     = count_q;
  assign full      = full_w;
  assign overflow  = overflow_q;
  assign state     = state_q;
  assign debug     = {eof_s, cr_s, next_char};
endmodule

// File: tb/tb_char_stream_buffer.sv
// tb_char_stream_buffer: scoreboard bench driving a deep and a 4-entry buffer with identical stimulus.
module tb_char_stream_buffer;
  logic        clk = 0, resetn = 1, char_ready = 0, eof = 0, restart = 0, out_ready = 0;
  logic [5:0]  next_char = 0;
  logic [11:0] sel = 0;
  logic [5:0]  sel_char_a, out_char_a, sel_char_b, out_char_b;
  logic        out_valid_a, out_valid_b, full_a, full_b, ovf_a, ovf_b;
  logic [12:0] count_a;
  logic [2:0]  count_b;
  logic [1:0]  state_a, state_b;
  logic [7:0]  debug_a, debug_b;
  int          checks = 0, errors = 0, hs_a = 0, hs_b = 0, nb = 0;
  logic [5:0]  qa[$], qb[$];

  always #5 clk = ~clk;

  char_stream_buffer dut_a (
    .clk(clk), .resetn(resetn), .char_ready(char_ready), .next_char(next_char), .eof(eof),
    .restart(restart), .sel(sel), .sel_char(sel_char_a), .out_char(out_char_a),
    .out_valid(out_valid_a), .out_ready(out_ready), .count(count_a), .full(full_a),
    .overflow(ovf_a), .state(state_a), .debug(debug_a)
  );

  char_stream_buffer #(.ADDR_W(2)) dut_b (
    .clk(clk), .resetn(resetn), .char_ready(char_ready), .next_char(next_char), .eof(eof),
    .restart(restart), .sel(sel[1:0]), .sel_char(sel_char_b), .out_char(out_char_b),
    .out_valid(out_valid_b), .out_ready(out_ready), .count(count_b), .full(full_b),
    .overflow(ovf_b), .state(state_b), .debug(debug_b)
  );

  initial begin
    logic st = 0;
    logic [5:0] st_char = 0, e;
    forever begin
      @(negedge clk);
      if (st) begin
        checks++;
        if (out_valid_a !== 1'b1 || out_char_a !== st_char) begin
          errors++;
          $display("FAIL hold_a: valid=%b char=%h, required valid=1 char=%h", out_valid_a, out_char_a, st_char);
        end
      end
      st = resetn && out_valid_a && !out_ready && !restart;
      st_char = out_char_a;
      if (resetn && out_valid_a && out_ready && !restart) begin
        checks++;
        hs_a++;
        if (qa.size() == 0) begin
          errors++;
          $display("FAIL stream_a: got %h, required no output", out_char_a);
        end else begin
          e = qa.pop_front();
          if (out_char_a !== e) begin
            errors++;
            $display("FAIL stream_a: got %h, required %h", out_char_a, e);
          end
        end
      end
    end
  end

  initial begin
    logic st = 0;
    logic [5:0] st_char = 0, e;
    forever begin
      @(negedge clk);
      if (st) begin
        checks++;
        if (out_valid_b !== 1'b1 || out_char_b !== st_char) begin
          errors++;
          $display("FAIL hold_b: valid=%b char=%h, required valid=1 char=%h", out_valid_b, out_char_b, st_char);
        end
      end
      st = resetn && out_valid_b && !out_ready && !restart;
      st_char = out_char_b;
      if (resetn && out_valid_b && out_ready && !restart) begin
        checks++;
        hs_b++;
        if (qb.size() == 0) begin
          errors++;
          $display("FAIL stream_b: got %h, required no output", out_char_b);
        end else begin
          e = qb.pop_front();
          if (out_char_b !== e) begin
            errors++;
            $display("FAIL stream_b: got %h, required %h", out_char_b, e);
          end
        end
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic expect_char(input logic [5:0] c);
    qa.push_back(c);
    if (nb < 4) qb.push_back(c);
    nb++;
  endtask

  task automatic strobe(input logic [5:0] c);
    expect_char(c);
    next_char = c;
    char_ready = 1;
    tick(4);
    char_ready = 0;
    tick(4);
  endtask

  task automatic pulse_restart();
    restart = 1;
    tick();
    restart = 0;
    qa.delete();
    qb.delete();
    nb = 0;
  endtask

  task automatic drain(input int budget, input bit toggle);
    logic [3:0] pat;
    int n;
    pat = 4'b1001;
    n = 0;
    while ((qa.size() != 0 || qb.size() != 0) && n < budget) begin
      out_ready = toggle ? pat[n % 4] : 1'b1;
      tick();
      n++;
    end
    out_ready = 0;
    checks++;
    if (qa.size() != 0 || qb.size() != 0) begin
      errors++;
      $display("FAIL drain: left a=%0d b=%0d, required 0", qa.size(), qb.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int base;
    #2 resetn = 0;
    tick(2);
    chk("rst_count", count_a, 0);
    chk("rst_state", state_a, 0);
    chk("rst_valid", out_valid_a, 0);
    chk("rst_full", full_a, 0);
    chk("rst_ovf", ovf_a, 0);
    chk("rst_out_char", out_char_a, 0);
    chk("rst_sel_char", sel_char_a, 0);
    resetn = 1;
    tick();

    for (int c = 1; c <= 5; c++) strobe(6'(c));
    eof = 1;
    tick(6);
    chk("l1_count_a", count_a, 5);
    chk("l1_state_a", state_a, 1);
    chk("l1_valid_a", out_valid_a, 1);
    chk("l1_full_a", full_a, 0);
    chk("l1_ovf_a", ovf_a, 0);
    chk("l1_count_b", count_b, 4);
    chk("l1_full_b", full_b, 1);
    chk("l1_ovf_b", ovf_b, 1);
    sel = 2;
    tick();
    chk("sel2_a", sel_char_a, 3);
    chk("sel2_b", sel_char_b, 3);
    sel = 7;
    tick();
    chk("sel7_a", sel_char_a, 0);
    chk("sel7_b", sel_char_b, 4);
    out_ready = 1;
    tick(5);
    out_ready = 0;
    chk("l1_left_a", qa.size(), 0);
    chk("l1_done_a", state_a, 2);
    chk("l1_done_valid_a", out_valid_a, 0);
    chk("l1_done_b", state_b, 2);
    sel = 4;
    tick(3);
    chk("done_sel4", sel_char_a, 5);
    chk("done_hold_state", state_a, 2);

    pulse_restart();
    chk("rs_count", count_a, 0);
    chk("rs_state", state_a, 0);
    chk("rs_ovf_b", ovf_b, 0);
    chk("rs_valid", out_valid_a, 0);
    eof = 0;
    tick(4);
    for (int c = 'h11; c <= 'h16; c++) strobe(6'(c));
    eof = 1;
    tick(6);
    chk("l2_count_a", count_a, 6);
    chk("l2_count_b", count_b, 4);
    chk("l2_ovf_b", ovf_b, 1);
    drain(80, 1);
    tick(2);
    chk("l2_done_a", state_a, 2);
    chk("l2_done_b", state_b, 2);

    pulse_restart();
    eof = 0;
    tick(4);
    strobe(6'h21);
    strobe(6'h22);
    expect_char(6'h23);
    next_char = 6'h23;
    char_ready = 1;
    eof = 1;
    tick(4);
    char_ready = 0;
    tick(4);
    chk("l3_count_a", count_a, 3);
    chk("l3_state_a", state_a, 1);
    drain(30, 0);
    tick(2);
    chk("l3_done_a", state_a, 2);

    pulse_restart();
    eof = 0;
    tick(4);
    for (int c = 'h31; c <= 'h34; c++) strobe(6'(c));
    eof = 1;
    tick(6);
    base = hs_a;
    out_ready = 1;
    for (int n = 0; n < 20 && hs_a < base + 2; n++) tick();
    out_ready = 0;
    chk("mid_handshakes", hs_a - base, 2);
    pulse_restart();
    chk("mid_valid_a", out_valid_a, 0);
    chk("mid_valid_b", out_valid_b, 0);
    chk("mid_count", count_a, 0);
    chk("mid_state", state_a, 0);
    eof = 0;
    tick(4);
    strobe(6'h0A);
    strobe(6'h0B);
    eof = 1;
    tick(6);
    chk("l4_count_a", count_a, 2);
    drain(30, 0);
    tick(2);
    chk("l4_done_a", state_a, 2);

    pulse_restart();
    eof = 0;
    tick(4);
    strobe(6'h15);
    strobe(6'h16);
    sel = 0;
    tick();
    chk("fill_sel0", sel_char_a, 6'h15);
    chk("fill_count", count_a, 2);
    #3 resetn = 0;
    #1;
    chk("arst_count_a", count_a, 0);
    chk("arst_count_b", count_b, 0);
    chk("arst_state", state_a, 0);
    chk("arst_sel_char", sel_char_a, 0);
    chk("arst_valid", out_valid_a, 0);
    chk("arst_out_char", out_char_a, 0);
    chk("arst_ovf", ovf_a, 0);
    qa.delete();
    qb.delete();
    nb = 0;
    tick(2);
    resetn = 1;
    tick(2);
    chk("post_rst_state", state_a, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/char_stream_buffer.md
Name: char_stream_buffer

Overview:
- Parametrised successor to the single-width character capture block.
- Captures characters from an asynchronous producer strobe (char_ready / next_char) into an internal buffer of 2^ADDR_W entries until end-of-file.
- After end-of-file, serves the stored text two ways: a random-access read port for the plotter glyph lookup, and an in-order valid/ready stream for the path generator.
- Adds input synchronisation, an overflow flag, a restart control and a character count, none of which the first generation had.

Parameters:
CHAR_W, 6, width of one character code
ADDR_W, 12, buffer address width; depth = 2^ADDR_W characters
SYNC_STAGES, 2, flip-flop stages on the char_ready and eof synchronisers (minimum 2)

Ports:
clk  in  1  system clock, all state on rising edge
resetn  in  1  asynchronous active-low reset
char_ready  in  1  asynchronous write strobe from the character source, high for one character
next_char  in  CHAR_W  character code, stable while char_ready is high
eof  in  1  asynchronous level, end of input text
restart  in  1  synchronous single-cycle pulse; discard contents and re-enter FILL
sel  in  ADDR_W  random-read address
sel_char  out  CHAR_W  registered random-read data
out_char  out  CHAR_W  stream data
out_valid  out  1  stream data valid
out_ready  in  1  stream consumer ready
count  out  ADDR_W+1  number of characters stored
full  out  1  count == 2^ADDR_W
overflow  out  1  sticky; a strobe arrived while full
state  out  2  FILL=0, LOADED=1, DONE=2
debug  out  CHAR_W+2  {eof_sync, char_ready_sync, next_char}

Behaviour:
Reset (resetn low, asynchronous):
- state=FILL; count=0; full=0; overflow=0; out_valid=0; out_char=0; sel_char=0.
- Stream and write pointers are set to 0.
- Buffer contents are not cleared.

Synchronisation:
- char_ready and eof each pass through SYNC_STAGES flip-flops.
- A rising-edge detector on synchronised char_ready produces a one-cycle write pulse.
- The write occurs SYNC_STAGES+1 cycles after char_ready rises.
- The producer must hold char_ready high and low for at least SYNC_STAGES+1 cycles each.

FILL:
- Each write pulse stores next_char at address count[ADDR_W-1:0] and increments count.
- When full, the write is dropped, count holds and overflow sets. overflow clears only on reset or restart.
- A rising edge of synchronised eof moves the state to LOADED on the next cycle.
- If a write pulse and the eof edge occur in the same cycle, the write completes first, then the state becomes LOADED.

LOADED / DONE:
- Write pulses are ignored; count is frozen.
- sel_char = buffer[sel] one cycle after sel is presented. If sel >= count, sel_char = 0.
- Stream read pointer starts at 0. out_valid rises no later than 2 cycles after entering LOADED (count>0).
- out_char and out_valid hold stable while out_ready is low.
- On out_valid && out_ready, the pointer advances and the next character is presented on the following cycle, sustaining one character per cycle under continuous out_ready.
- After the handshake on character count-1, out_valid drops and state becomes DONE on the next cycle.
- count==0 at eof: go LOADED then immediately DONE; out_valid never asserts.

DONE:
- Random reads remain available.
- Stream is idle with out_valid=0.
- Only restart or reset leaves DONE.

restart (any state):
- Next cycle: state=FILL, count=0, overflow=0, out_valid=0, pointers reset.
- A write pulse coinciding with restart is discarded.
- eof must fall and rise again to reload.
- restart has priority over every other event.

Test Plan:
- Reset, then 5 strobes carrying 0x01,0x02,0x03,0x04,0x05, then eof high -> count=5, state=LOADED; stream with out_ready=1 emits 0x01..0x05 on consecutive cycles; state=DONE after the 5th handshake.
- After load, sel=2 -> sel_char=0x03 one cycle later; sel=7 -> sel_char=0.
- ADDR_W=2: 5 strobes -> count=4, full=1, overflow=1; stream emits only the first 4 characters.
- Stream with out_ready toggling 1,0,0,1 -> out_char holds value during stall; no character is lost or duplicated.
- eof rising in the same cycle as the 3rd write pulse -> count=3, third character present in the stream.
- restart mid-stream after 2 handshakes -> out_valid=0 next cycle, count=0, state=FILL; a new load of 0x0A,0x0B streams correctly; resetn low mid-FILL -> all outputs return to reset values immediately.
